// File: rtl/alu_div_8b_pkg.sv
// Shared ALU definitions for the sequential divider: default width,
// FSM encoding and the divide-by-zero quotient constant.
package alu_div_8b_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/alu_sub_nb.sv
// N-bit ripple subtractor: a + ~b + 1 through a chain of full-adder cells.
// borrow is the inverted carry-out of the chain.
module alu_sub_nb #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0]   c;
    logic [N-1:0] b_n;

    assign c[0] = 1'b1;
    assign b_n  = ~b;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign diff[i]  = a[i] ^ b_n[i] ^ c[i];
        assign c[i+1]   = (a[i] & b_n[i]) | (c[i] & (a[i] ^ b_n[i]));
    end

    assign borrow = ~c[N];

endmodule

// File: rtl/alu_div_8b.sv
// Restoring unsigned divider: one quotient bit per clock, start/busy/done
// handshake, results held until the next accepted start.
module alu_div_8b
    import alu_div_8b_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] q_sh_q, q_sh_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             accept, last, take;
    logic [WIDTH:0]   t_a, t_diff;
    logic             t_borrow;

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign last   = (cnt_q == CNT_W'(WIDTH - 1));

    // Trial subtraction of the divisor from the shifted partial remainder
    assign t_a = {p_q, q_sh_q[WIDTH-1]};

    alu_sub_nb #(.N(WIDTH + 1)) u_sub (
        .a      (t_a),
        .b      ({1'b0, dvsr_q}),
        .diff   (t_diff),
        .borrow (t_borrow)
    );

    // P < divisor is invariant, so a non-borrowing result never sets the top bit
    assign take = ~(t_diff[WIDTH] | t_borrow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvsr_q  <= '0;
            q_sh_q  <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvsr_q  <= dvsr_d;
            q_sh_q  <= q_sh_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (divisor == '0) ? DONE : RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = accept ? ((divisor == '0) ? DONE : RUN) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        dvsr_d = dvsr_q;
        q_sh_d = q_sh_q;
        p_d    = p_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (accept) begin
            if (divisor == '0) begin
                quot_d = {WIDTH{&DIV_ZERO_Q}};
                rem_d  = dividend;
                dbz_d  = 1'b1;
            end else begin
                dvsr_d = divisor;
                q_sh_d = dividend;
                p_d    = '0;
                cnt_d  = '0;
            end
        end else if (state_q == RUN) begin
            p_d    = take ? t_diff[WIDTH-1:0] : t_a[WIDTH-1:0];
            q_sh_d = {q_sh_q[WIDTH-2:0], take};
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
                quot_d = q_sh_d;
                rem_d  = p_d;
                dbz_d  = 1'b0;
            end
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_div_8b.sv
// Randomized self-checking bench for alu_div_8b against an arithmetic model.
module tb_alu_div_8b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] prev_q = '0, prev_r = '0;
    logic       prev_z = 1'b0;

    alu_div_8b dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called #1 after the accepting edge; follows the op to its done edge.
    task automatic finish_op(input logic [7:0] a, input logic [7:0] b, input bit inj);
        logic [7:0] eq, er;
        eq = (b == 0) ? 8'hFF : a / b;
        er = (b == 0) ? a : a % b;
        if (b == 0) begin
            chk("dz_busy", busy, 0);
            chk("dz_done", done, 1);
            chk("dz_q", quotient, eq);
            chk("dz_r", remainder, er);
            chk("dz_flag", div_by_zero, 1);
        end else begin
            chk("acc_busy", busy, 1);
            chk("acc_done", done, 0);
            chk("acc_hold_q", quotient, prev_q);
            chk("acc_hold_r", remainder, prev_r);
            chk("acc_hold_z", div_by_zero, prev_z);
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk); #1;
                if (inj && k == 4) start = 1'b0;
                if (k < 8) begin
                    chk("run_busy", busy, 1);
                    chk("run_done", done, 0);
                    chk("run_hold_q", quotient, prev_q);
                end else begin
                    chk("fin_busy", busy, 0);
                    chk("fin_done", done, 1);
                    chk("fin_q", quotient, eq);
                    chk("fin_r", remainder, er);
                    chk("fin_dz", div_by_zero, 0);
                end
                if (inj && k == 3) begin
                    start    = 1'b1;
                    dividend = 8'($urandom);
                    divisor  = 8'($urandom_range(1, 255));
                end
            end
        end
        prev_q = eq;
        prev_r = er;
        prev_z = (b == 0);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit inj);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        finish_op(a, b, inj);
    endtask

    task automatic idle_step();
        @(posedge clk); #1;
        chk("done_pulse_end", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        bit saw_done;
        logic [7:0] ra, rb;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        issue(8'd100, 8'd7, 0); idle_step();
        issue(8'd255, 8'd1, 0); idle_step();
        issue(8'd5, 8'd9, 0); idle_step();
        issue(8'd0, 8'd3, 0); idle_step();
        issue(8'd255, 8'd255, 0); idle_step();
        issue(8'd42, 8'd0, 0); idle_step();
        issue(8'd9, 8'd3, 0); idle_step();

        // start pulse mid-run is ignored
        issue(8'd123, 8'd11, 1); idle_step();

        // start held through DONE: back-to-back accept
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1;
        dividend = 8'd200; divisor = 8'd13;
        finish_op(8'd100, 8'd7, 0);
        @(posedge clk); #1;
        start = 1'b0;
        finish_op(8'd200, 8'd13, 0);
        idle_step();

        // asynchronous reset mid-run, no done afterwards
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        chk("arst_dz", div_by_zero, 0);
        @(negedge clk); rst_n = 1'b1;
        saw_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1;
        end
        chk("arst_no_done", saw_done, 0);
        prev_q = '0; prev_r = '0; prev_z = 1'b0;
        issue(8'd77, 8'd10, 0); idle_step();

        // randomized ops, occasionally back-to-back
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            issue(ra, rb, ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 1) == 1) idle_step();
        end
        idle_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
